// File: rtl/int_sequencer.sv
// int_sequencer: latches masked interrupt requests, grants one, and drives a SEQ_LEN-cycle fire sequence.
// Define INT_SEQ_ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed lowest-index priority.
module int_sequencer #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2,
  parameter int SEQ_LEN = 5,
  parameter int CNT_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] int_req,
  input  logic [NUM_SRC-1:0] int_mask,
  input  logic               stall,
  output logic               fire_int,
  output logic [CNT_W-1:0]   count,
  output logic [ID_W-1:0]    int_id,
  output logic [NUM_SRC-1:0] pending,
  output logic               int_start,
  output logic               int_done
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SEQ_LEN - 1);
  state_t             state_q, state_d;
  logic               fire_int_q, fire_int_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ID_W-1:0]    int_id_q, int_id_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic               int_start_q, int_start_d;
  logic [NUM_SRC-1:0] cand, grant_onehot;
  logic [ID_W-1:0]    win_id;
  logic               found, grant;
`ifdef INT_SEQ_ROUND_ROBIN_EN
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (!found && cand[(int'(rr_ptr_q) + i) % NUM_SRC]) begin
        found  = 1'b1;
        win_id = ID_W'((int'(rr_ptr_q) + i) % NUM_SRC);
      end
  end
  assign rr_ptr_d = grant ? ((win_id == ID_W'(NUM_SRC - 1)) ? '0 : win_id + 1'b1) : rr_ptr_q;
  always_ff @(posedge clk)
    rr_ptr_q <= reset ? '0 : rr_ptr_d;
`else
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (cand[i]) begin
        found  = 1'b1;
        win_id = ID_W'(i);
      end
  end
`endif
  assign cand         = (pending_q | int_req) & ~int_mask;
  assign grant        = (state_q == IDLE) && found;
  assign grant_onehot = grant ? (NUM_SRC'(1) << win_id) : '0;
  always_comb begin
    state_d     = state_q;
    fire_int_d  = fire_int_q;
    count_d     = count_q;
    int_id_d    = int_id_q;
    int_start_d = 1'b0;
    pending_d   = (pending_q | int_req) & ~grant_onehot;
    if (state_q == IDLE) begin
      fire_int_d  = grant;
      count_d     = '0;
      int_start_d = grant;
      int_id_d    = grant ? win_id : int_id_q;
      state_d     = grant ? ACTIVE : IDLE;
    end else if (!stall) begin
      // Returning to IDLE here guarantees the mandatory idle gap before the next grant.
      fire_int_d = count_q != LAST;
      count_d    = (count_q == LAST) ? '0 : count_q + 1'b1;
      state_d    = (count_q == LAST) ? IDLE : ACTIVE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      fire_int_q  <= 1'b0;
      count_q     <= '0;
      int_id_q    <= '0;
      pending_q   <= '0;
      int_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fire_int_q  <= fire_int_d;
      count_q     <= count_d;
      int_id_q    <= int_id_d;
      pending_q   <= pending_d;
      int_start_q <= int_start_d;
    end
  end
  assign fire_int  = fire_int_q;
  assign count     = count_q;
  assign int_id    = int_id_q;
  assign pending   = pending_q;
  assign int_start = int_start_q;
  assign int_done  = fire_int_q && (count_q == LAST) && !stall;
endmodule

// File: tb/tb_int_sequencer.sv
// tb_int_sequencer: directed tests for int_sequencer with hand-computed expectations.
module tb_int_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] int_req = '0;
  logic [3:0] int_mask = '0;
  logic       stall = 1'b0;
  logic       fire_int, int_start, int_done;
  logic [2:0] count;
  logic [1:0] int_id;
  logic [3:0] pending;
  logic [10:0] obs;
  int passed = 0;
  int total = 0;

  int_sequencer dut (
    .clk(clk), .reset(reset), .int_req(int_req), .int_mask(int_mask), .stall(stall),
    .fire_int(fire_int), .count(count), .int_id(int_id), .pending(pending),
    .int_start(int_start), .int_done(int_done)
  );

  always #5 clk = ~clk;
  assign obs = {fire_int, count, int_id, pending, int_start};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    int_req = 4'b1111;
    step();
    step();
    total++;
    if (obs !== 11'b0) $display("FAIL reset_state: got %b expected %b", obs, 11'b0);
    else passed++;
    reset = 1'b0;
    int_req = '0;
    step();
    total++;
    if (obs !== 11'b0) $display("FAIL reset_release: got %b expected %b", obs, 11'b0);
    else passed++;
  endtask

  task automatic test_single();
    int_req = 4'b0100;
    step();
    int_req = '0;
    total++;
    if (obs !== {1'b1, 3'd0, 2'd2, 4'b0000, 1'b1})
      $display("FAIL single_grant: got %b expected %b", obs, {1'b1, 3'd0, 2'd2, 4'b0000, 1'b1});
    else passed++;
    for (int c = 1; c <= 4; c++) begin
      step();
      total++;
      if ({fire_int, count, int_start} !== {1'b1, 3'(c), 1'b0})
        $display("FAIL single_count%0d: got %b expected %b", c, {fire_int, count, int_start}, {1'b1, 3'(c), 1'b0});
      else passed++;
      total++;
      if (int_done !== (c == 4))
        $display("FAIL single_done%0d: got %b expected %b", c, int_done, c == 4);
      else passed++;
    end
    step();
    total++;
    if ({fire_int, count, int_done} !== 5'b0)
      $display("FAIL single_end: got %b expected %b", {fire_int, count, int_done}, 5'b0);
    else passed++;
  endtask

  task automatic test_priority();
    logic [10:0] e1, e2, e3, e4;
`ifdef INT_SEQ_ROUND_ROBIN_EN
    e1 = {1'b1, 3'd0, 2'd3, 4'b0010, 1'b1};
    e2 = {1'b0, 3'd0, 2'd3, 4'b0010, 1'b0};
    e3 = {1'b1, 3'd0, 2'd1, 4'b0000, 1'b1};
    e4 = {1'b0, 3'd0, 2'd1, 4'b0000, 1'b0};
`else
    e1 = {1'b1, 3'd0, 2'd1, 4'b1000, 1'b1};
    e2 = {1'b0, 3'd0, 2'd1, 4'b1000, 1'b0};
    e3 = {1'b1, 3'd0, 2'd3, 4'b0000, 1'b1};
    e4 = {1'b0, 3'd0, 2'd3, 4'b0000, 1'b0};
`endif
    int_req = 4'b1010;
    step();
    int_req = '0;
    total++;
    if (obs !== e1) $display("FAIL prio_first: got %b expected %b", obs, e1);
    else passed++;
    repeat (5) step();
    total++;
    if (obs !== e2) $display("FAIL prio_gap: got %b expected %b", obs, e2);
    else passed++;
    step();
    total++;
    if (obs !== e3) $display("FAIL prio_second: got %b expected %b", obs, e3);
    else passed++;
    repeat (5) step();
    total++;
    if (obs !== e4) $display("FAIL prio_drain: got %b expected %b", obs, e4);
    else passed++;
    int_req = 4'b0011;
    step();
    int_req = '0;
    total++;
    if (obs !== {1'b1, 3'd0, 2'd0, 4'b0010, 1'b1})
      $display("FAIL pair_first: got %b expected %b", obs, {1'b1, 3'd0, 2'd0, 4'b0010, 1'b1});
    else passed++;
    repeat (6) step();
    total++;
    if (obs !== {1'b1, 3'd0, 2'd1, 4'b0000, 1'b1})
      $display("FAIL pair_second: got %b expected %b", obs, {1'b1, 3'd0, 2'd1, 4'b0000, 1'b1});
    else passed++;
    repeat (5) step();
  endtask

  task automatic test_mask();
    int_mask = 4'b0001;
    int_req = 4'b0001;
    step();
    int_req = '0;
    total++;
    if (obs !== {1'b0, 3'd0, 2'd1, 4'b0001, 1'b0})
      $display("FAIL mask_latch: got %b expected %b", obs, {1'b0, 3'd0, 2'd1, 4'b0001, 1'b0});
    else passed++;
    step();
    total++;
    if (obs !== {1'b0, 3'd0, 2'd1, 4'b0001, 1'b0})
      $display("FAIL mask_hold: got %b expected %b", obs, {1'b0, 3'd0, 2'd1, 4'b0001, 1'b0});
    else passed++;
    int_mask = '0;
    step();
    total++;
    if (obs !== {1'b1, 3'd0, 2'd0, 4'b0000, 1'b1})
      $display("FAIL mask_release: got %b expected %b", obs, {1'b1, 3'd0, 2'd0, 4'b0000, 1'b1});
    else passed++;
    repeat (5) step();
  endtask

  task automatic test_stall();
    int act;
    int_req = 4'b0100;
    step();
    int_req = '0;
    act = int'(fire_int);
    repeat (2) begin
      step();
      act += int'(fire_int);
    end
    stall = 1'b1;
    total++;
    if ({count, int_done} !== {3'd2, 1'b0})
      $display("FAIL stall_enter: got %b expected %b", {count, int_done}, {3'd2, 1'b0});
    else passed++;
    repeat (3) begin
      step();
      act += int'(fire_int);
      total++;
      if ({fire_int, count, int_done} !== {1'b1, 3'd2, 1'b0})
        $display("FAIL stall_hold: got %b expected %b", {fire_int, count, int_done}, {1'b1, 3'd2, 1'b0});
      else passed++;
    end
    stall = 1'b0;
    repeat (3) begin
      step();
      act += int'(fire_int);
    end
    total++;
    if (act !== 8) $display("FAIL stall_length: got %0d expected %0d", act, 8);
    else passed++;
    total++;
    if (fire_int !== 1'b0) $display("FAIL stall_end: got %b expected %b", fire_int, 1'b0);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int_req = 4'b0100;
    step();
    int_req = 4'b0010;
    step();
    int_req = '0;
    repeat (2) step();
    total++;
    if (obs !== {1'b1, 3'd3, 2'd2, 4'b0010, 1'b0})
      $display("FAIL mid_before: got %b expected %b", obs, {1'b1, 3'd3, 2'd2, 4'b0010, 1'b0});
    else passed++;
    reset = 1'b1;
    step();
    total++;
    if (obs !== 11'b0) $display("FAIL mid_reset: got %b expected %b", obs, 11'b0);
    else passed++;
    reset = 1'b0;
    repeat (3) begin
      step();
      total++;
      if ({fire_int, pending} !== 5'b0)
        $display("FAIL mid_after: got %b expected %b", {fire_int, pending}, 5'b0);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
